// File: rtl/serial_word_queue_pkg.sv
// Shared types and reset constants for serial_word_queue and its circular queue.
package serial_word_queue_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      PUSH  = 2'd2,
      STALL = 2'd3
   } deser_state_t;

   localparam deser_state_t RST_STATE    = IDLE;
   localparam logic         RST_OVERFLOW = 1'b0;
   // Registered dequeue copy starts high so a level held through reset is not a rising edge.
   localparam logic         RST_DEQ_PREV = 1'b1;

endpackage

// File: rtl/serial_word_queue_circ_queue.sv
// Circular word queue with first-word fall-through head output; head reads as 0 when empty.
module circ_queue
   import serial_word_queue_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_in,
   input  logic [WIDTH-1:0]           push_data_in,
   input  logic                       pop_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH+1)-1:0] len_out,
   output logic                       full_out,
   output logic                       empty_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LEN_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             pop_ok;
   logic             push_ok;

   always_comb begin
      pop_ok  = pop_in && (len_q != '0);
      // A pop on a full queue frees the slot the same-edge push lands in.
      push_ok = push_in && ((len_q != LEN_W'(DEPTH)) || pop_ok);
      head_d  = head_q;
      tail_d  = tail_q;
      len_d   = len_q;
      mem_d   = mem_q;
      if (push_ok) begin
         mem_d[tail_q] = push_data_in;
         tail_d        = tail_q + PTR_W'(1);
      end
      if (pop_ok) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         len_d = len_q + LEN_W'(1);
      end else if (pop_ok && !push_ok) begin
         len_d = len_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         len_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         len_q  <= len_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign data_out  = (len_q == '0) ? '0 : mem_q[head_q];
   assign len_out   = len_q;
   assign full_out  = (len_q == LEN_W'(DEPTH));
   assign empty_out = (len_q == '0);

endmodule

// File: rtl/serial_word_queue.sv
// Serial-to-word deserializer feeding a circular queue, with stall on full and sticky overflow.
// Define DEQ_EDGE_EN for rising-edge-detected pops; otherwise pops are level-sensitive.
module serial_word_queue
   import serial_word_queue_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       data_in,
   input  logic                       write_in,
   output logic                       status_out,
   input  logic                       dequeue_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH+1)-1:0] len_out,
   output logic                       full_out,
   output logic                       empty_out,
   output logic                       overflow_out
);

   localparam int CNT_W = $clog2(WIDTH+1);

   deser_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] bit_pos;
   logic             status;
   logic             push;
   logic             pop_req;
   logic             pop_acc;
   logic             q_full;
   logic             q_empty;

`ifdef DEQ_EDGE_EN
   logic deq_prev_q, deq_prev_d;

   always_comb begin
      deq_prev_d = dequeue_in;
      pop_req    = dequeue_in && !deq_prev_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         deq_prev_q <= RST_DEQ_PREV;
      end else begin
         deq_prev_q <= deq_prev_d;
      end
   end
`else
   always_comb begin
      pop_req = dequeue_in;
   end
`endif

   assign pop_acc = pop_req && !q_empty;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      overflow_d = overflow_q;
      status     = 1'b0;
      push       = 1'b0;
      bit_pos    = (LSB_FIRST != 0) ? cnt_q : (CNT_W'(WIDTH-1) - cnt_q);
      case (state_q)
         IDLE: begin
            state_d = READY;
         end
         READY: begin
            status = 1'b1;
            if (write_in) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (i == int'(bit_pos)) shreg_d[i] = data_in;
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  state_d = q_full ? STALL : PUSH;
               end
            end
         end
         PUSH: begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = READY;
         end
         STALL: begin
            // Leave as soon as this cycle's pop makes room.
            if (!q_full || pop_acc) state_d = PUSH;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (write_in && !status) overflow_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RST_STATE;
         cnt_q      <= '0;
         overflow_q <= RST_OVERFLOW;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clock) begin
      shreg_q <= shreg_d;
   end

   circ_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_queue (
      .clock        (clock),
      .reset        (reset),
      .push_in      (push),
      .push_data_in (shreg_q),
      .pop_in       (pop_acc),
      .data_out     (data_out),
      .len_out      (len_out),
      .full_out     (q_full),
      .empty_out    (q_empty)
   );

   assign status_out   = status;
   assign full_out     = q_full;
   assign empty_out    = q_empty;
   assign overflow_out = overflow_q;

endmodule

// File: doc/serial_word_queue.md
# serial_word_queue

Parametrised successor to the deserializer/queue pair. It assembles a `WIDTH`-bit word from a strobed serial bit stream and pushes each completed word into an internal circular queue of `DEPTH` entries. The head word is always presented on `data_out`. Compared with the fixed 8-bit/8-entry pair, it adds:
- configurable bit order;
- back-pressure stall when the queue is full;
- a sticky overflow flag;
- full and empty outputs.

## Interface
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `DEPTH`, default 8: queue entries; must be a power of two, ≥ 2.
- `LSB_FIRST`, default 1: 1 = first serial bit lands in bit 0; 0 = first bit lands in bit `WIDTH-1`.
- `clock` in 1: the single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in 1: serial data bit, sampled when `write_in`=1.
- `write_in` in 1: bit strobe; one bit is consumed per cycle in which it is high.
- `status_out` out 1: 1 = deserializer is ready to accept bits.
- `dequeue_in` in 1: pop request (see Configuration).
- `data_out` out `WIDTH`: head entry of the queue; 0 when empty.
- `len_out` out `$clog2(DEPTH+1)`: number of entries currently held, 0..`DEPTH`.
- `full_out` out 1: high when `len_out` == `DEPTH`.
- `empty_out` out 1: high when `len_out` == 0.
- `overflow_out` out 1: sticky; set when a strobed bit is dropped; cleared only by `reset`.

## Operation
The deserializer FSM has four states: IDLE, READY, PUSH, STALL.

- **IDLE**
  - Entered on reset.
  - `status_out`=0.
  - Always moves to READY on the next cycle.
- **READY**
  - `status_out`=1.
  - Each `write_in`=1 cycle shifts `data_in` into the shift register and increments the bit counter.
  - Bit placement:
    - `LSB_FIRST`=1: bit k goes to position k.
    - `LSB_FIRST`=0: bit k goes to position `WIDTH-1-k`.
  - When the `WIDTH`-th bit is sampled:
    - if the queue is not full, go to PUSH;
    - if it is full, go to STALL.
- **PUSH**
  - `status_out`=0.
  - The word is written at the tail; tail and `len_out` advance.
  - The bit counter clears.
  - Returns to READY on the next cycle.
- **STALL**
  - `status_out`=0.
  - The completed word is held.
  - Moves to PUSH on the first cycle in which the queue is not full, as seen after that cycle's pop.
- **Dropped bits**
  - Any `write_in`=1 while `status_out`=0 (IDLE, PUSH or STALL) is discarded and sets `overflow_out`.

Queue behaviour:
- Circular buffer with head and tail pointers of `$clog2(DEPTH)` bits; both wrap modulo `DEPTH`.
- A pop with `empty_out`=1 is ignored; it does not affect flags.
- Push and pop in the same cycle: both take effect, and `len_out` is unchanged.
- Push and pop when `len_out`=0: the push is written and the pop is ignored.

## Timing
- **Reset values:**
  - `status_out`=0, `data_out`=0, `len_out`=0;
  - `full_out`=0, `empty_out`=1, `overflow_out`=0;
  - FSM in IDLE, bit counter 0, pointers 0.
- `status_out` rises 1 cycle after `reset` deasserts.
- The last bit is sampled at edge t (FSM enters PUSH). At edge t+1 the entry is written; `len_out`, `data_out` (if the queue was empty) and `empty_out` update after edge t+1. `status_out` returns high after edge t+1.
- Pop accepted at edge t: `data_out` shows the next head and `len_out` decrements after edge t, i.e. zero-latency first-word fall-through.
- STALL exit: a pop at edge t moves the FSM to PUSH after edge t; the word is written at edge t+1.
- `reset` asserted mid-word or in STALL: the partial or held word is discarded, queue contents are invalidated, and all outputs return to their reset values on that edge.

## Configuration
- `DEQ_EDGE_EN` defined:
  - `dequeue_in` is edge-detected through a registered copy.
  - Exactly one pop occurs on the cycle `dequeue_in` goes 0→1, regardless of how long it is held.
  - The registered copy resets to 1, so an input held high through reset does not pop.
- `DEQ_EDGE_EN` undefined:
  - level-sensitive pop;
  - one pop per cycle while `dequeue_in`=1 and the queue is not empty.

## Structure
- Shared package `serial_word_queue_pkg` holds:
  - enum `deser_state_t` {IDLE, READY, PUSH, STALL};
  - reset-value constants.
- One sub-module, `circ_queue`, holds storage, pointers, `len`, full/empty and `data_out`. It has push/pop/data ports and is parametrised on `WIDTH` and `DEPTH`.
- The top level holds the FSM, shift register, bit counter, the overflow flag and the `DEQ_EDGE_EN` logic.

## Test plan
1. **Reset and basic word.** Reset for 3 cycles, then send 8'h99 with `LSB_FIRST`=1 → `status_out` high 1 cycle after reset; after the 8th bit, `len_out`=1 and `data_out`=8'h99 within 2 cycles.
2. **Bit order.** Send 0x01, 0x02, 0x03, 0x04, then `LSB_FIRST`=0 with bits 1,0,0,0,0,0,0,0 →
   - first run: `len_out`=4, `data_out`=0x01;
   - MSB-first run: stored word is 0x80.
3. **Full and stall.** Fill 8 words, then send a 9th word → `full_out`=1 and `status_out` stays 0 in STALL. Extra strobes set `overflow_out`=1. One pop → the 9th word enters at the tail and `len_out` returns to 8.
4. **Pop behaviour.** Hold `dequeue_in` high for 20 cycles with 4 words queued →
   - with `DEQ_EDGE_EN` defined: `len_out`=3;
   - with it undefined: `len_out`=0, `empty_out`=1, `data_out`=0, and no underflow side effects.
5. **Wrap and simultaneous push/pop.** Cycle 20 words through the 8-deep queue while popping → FIFO order is preserved across pointer wrap. A push and pop on the same edge leaves `len_out` unchanged.
6. **Reset mid-operation.** Assert `reset` after 5 of 8 bits, with 3 words queued → all outputs return to reset values. The next full word stored afterwards contains no stale bits.
